muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multiply/divide sequencer and HI/LO owner for the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from execute and drives an external fixed-latency multiplier and the iterative `div` core through its start/annul/ready handshake. Stalls the pipeline until results are committed and holds the architectural HI/LO registers. Replaces the ad-hoc stall and HI/LO write logic in execute.

## Interface
- `MUL_LAT`, default 2: external multiplier latency in cycles; legal range 1..8.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: execute holds a HI/LO-class op this cycle.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `src1`, `src2` in 32: rs and rt operand values.
- `flush` in 1: cancels any accepted or in-flight op.
- `stall_o` out 1: holds execute and the earlier stages.
- `mf_data` out 32: MFHI/MFLO result; 0 when not an MF op.
- `mf_valid` out 1: `mf_data` is meaningful.
- `hi`, `lo` out 32: architectural HI/LO (registered).
- `busy` out 1: state is not IDLE.
- `mul_a`, `mul_b` out 32: registered multiplier operands.
- `mul_signed` out 1: registered signed-multiply flag.
- `mul_result` in 64: {hi, lo} product, valid MUL_LAT cycles after accept (see Timing).
- `div_opa`, `div_opb` out 32: registered dividend and divisor.
- `div_signed` out 1: registered signed-divide flag.
- `div_start` out 1: level request to the `div` core.
- `div_annul` out 1: one-cycle cancel pulse to the `div` core.
- `div_result` in 64: [63:32] remainder goes to HI; [31:0] quotient goes to LO.
- `div_ready` in 1: `div_result` valid.

## Operation
- FSM states: IDLE, MUL_WAIT, DIV_WAIT.
- **IDLE, `op_valid` && !`flush`:**
  - MULT/MULTU: latch operands to `mul_*`; load the counter with MUL_LAT-1; go to MUL_WAIT.
  - DIV/DIVU with `src2` != 0: latch operands to `div_*`; go to DIV_WAIT.
  - DIV/DIVU with `src2` == 0: no request is issued, HI/LO are unchanged, no stall, state stays IDLE.
  - MTHI/MTLO: write `src1` to `hi`/`lo` at the cycle end; no stall.
  - MFHI/MFLO: `mf_data` = current `hi`/`lo` (combinational); `mf_valid` = 1; no stall.
- **MUL_WAIT:**
  - Counter decrements each cycle.
  - When the counter is 0: sample `mul_result` into {`hi`, `lo`}; return to IDLE.
- **DIV_WAIT:**
  - `div_start` = 1.
  - In the cycle `div_ready` = 1: sample `div_result` into `hi` (remainder) and `lo` (quotient); return to IDLE. `div_start` = 0 from the next cycle.
- **In wait states**, `op_valid`/`op`/`src*` are ignored; execute is re-presenting the same op.
- **Flush:**
  - In a wait state: discard; no HI/LO write; go to IDLE.
  - In DIV_WAIT, a flush also drives `div_annul` = 1 for that cycle with `div_start` = 0.
  - Flush in IDLE: the op is not accepted and no MT write occurs.
  - Flush coincident with the commit cycle: flush wins and HI/LO are unchanged.
- **`stall_o`:**
  - 1 in the accept cycle of MULT/MULTU/DIV/DIVU (nonzero divisor, no flush).
  - 1 in MUL_WAIT while counter != 0.
  - 1 in DIV_WAIT while `div_ready` = 0 and `flush` = 0.
  - 0 otherwise.
- **Reset:** state IDLE, counter 0, `hi` = `lo` = 0, and every output 0 (`mul_*`, `div_*`, `div_start`, `div_annul`, `stall_o`, `busy`, `mf_*`). Reset mid-operation abandons the op silently; `div_annul` is not pulsed, because `div` shares `rst`.

## Timing
- Cycle numbering: the accept cycle is c0.
- **MULT/MULTU:**
  - `mul_*` are valid from c1.
  - Commit is sampled at the end of cycle c(MUL_LAT).
  - `stall_o` is high c0..c(MUL_LAT-1), i.e. MUL_LAT stall cycles.
  - New HI/LO are visible from c(MUL_LAT+1).
- **DIV/DIVU:**
  - `div_start` is high from c1 until the `div_ready` cycle.
  - `stall_o` drops in the `div_ready` cycle.
  - HI/LO update at the end of that cycle.
- **MTHI/MTLO:** `hi`/`lo` are visible the cycle after the op.
- **Back-to-back ops:** an MF op in the cycle after a commit reads the new value. Because mult/div stall until commit, MF never reads stale data.
- **Arithmetic:** no arithmetic inside the block; signed/unsigned handling is delegated via `mul_signed`/`div_signed`. `mul_signed` = `div_signed` = 1 for MULT/DIV.

## Test plan
- **MULT:** MUL_LAT=3, MULT `src1`=3, `src2`=0xFFFFFFFE, model returns the product.
  - `stall_o` is high c0–c2 and low in c3.
  - From c4: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- **DIVU:** DIVU 100/7, `div` model asserts ready at c5.
  - `div_start` is high c1–c5.
  - `stall_o` is low in c5.
  - From c6: `hi`=2, `lo`=14.
- **Divide by zero:** DIV with `src2`=0.
  - `stall_o`=0 and `div_start` never asserts.
  - HI/LO keep their prior values.
- **Flush at c3 of a DIV:**
  - `div_annul`=1 for one cycle in c3; `stall_o`=0 in c3.
  - HI/LO are unchanged; `busy`=0 in c4.
- **MTHI then MFHI:** MTHI 0x12345678, then MFHI next cycle.
  - `mf_data`=0x12345678 with `mf_valid`=1.
  - MFLO after reset returns 0.
- **Reset mid-MULT:** assert `rst` at c1.
  - Next cycle: state IDLE, all outputs 0, `hi`=`lo`=0.
  - A later `mul_result` is ignored.

Source files
------------

// File: rtl/muldiv_seq.sv
// HI/LO owner and multiply/divide sequencer for the execute stage.
// Drives an external fixed-latency multiplier and the iterative div core, stalling until commit.
module muldiv_seq #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_signed,
    output logic        div_start,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_signed;
    logic [31:0] r_div_opa;
    logic [31:0] r_div_opb;
    logic        r_div_signed;

    logic        w_mul_load;
    logic        w_div_load;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mul_load  = 1'b0;
        w_div_load  = 1'b0;
        w_hi_we     = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        stall_o     = 1'b0;
        mf_data     = 32'd0;
        mf_valid    = 1'b0;
        div_start   = 1'b0;
        div_annul   = 1'b0;

        // Combinational outputs stay quiet while reset is held.
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                w_mul_load  = 1'b1;
                                w_cnt_nxt   = CNT_LOAD;
                                w_state_nxt = S_MUL_WAIT;
                                stall_o     = 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                // A zero divisor is dropped: HI/LO keep their values.
                                if (src2 != 32'd0) begin
                                    w_div_load  = 1'b1;
                                    w_state_nxt = S_DIV_WAIT;
                                    stall_o     = 1'b1;
                                end
                            end
                            OP_MTHI: begin
                                w_hi_we  = 1'b1;
                                w_hi_nxt = src1;
                            end
                            OP_MTLO: begin
                                w_lo_we  = 1'b1;
                                w_lo_nxt = src1;
                            end
                            OP_MFHI: begin
                                mf_data  = r_hi;
                                mf_valid = 1'b1;
                            end
                            OP_MFLO: begin
                                mf_data  = r_lo;
                                mf_valid = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL_WAIT: begin
                    stall_o = (r_cnt != 3'd0);
                    if (flush) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == 3'd0) begin
                        w_hi_we     = 1'b1;
                        w_lo_we     = 1'b1;
                        w_hi_nxt    = mul_result[63:32];
                        w_lo_nxt    = mul_result[31:0];
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                S_DIV_WAIT: begin
                    if (flush) begin
                        div_annul   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        div_start = 1'b1;
                        if (div_ready) begin
                            w_hi_we     = 1'b1;
                            w_lo_we     = 1'b1;
                            w_hi_nxt    = div_result[63:32];
                            w_lo_nxt    = div_result[31:0];
                            w_state_nxt = S_IDLE;
                        end else begin
                            stall_o = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_mul_a      <= 32'd0;
            r_mul_b      <= 32'd0;
            r_mul_signed <= 1'b0;
            r_div_opa    <= 32'd0;
            r_div_opb    <= 32'd0;
            r_div_signed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_hi_we) r_hi <= w_hi_nxt;
            if (w_lo_we) r_lo <= w_lo_nxt;
            if (w_mul_load) begin
                r_mul_a      <= src1;
                r_mul_b      <= src2;
                r_mul_signed <= (op == OP_MULT);
            end
            if (w_div_load) begin
                r_div_opa    <= src1;
                r_div_opb    <= src2;
                r_div_signed <= (op == OP_DIV);
            end
        end
    end

    assign hi         = r_hi;
    assign lo         = r_lo;
    assign busy       = (r_state != S_IDLE);
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_signed = r_mul_signed;
    assign div_opa    = r_div_opa;
    assign div_opb    = r_div_opb;
    assign div_signed = r_div_signed;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scripted bench for muldiv_seq: cycle-exact handshake checks plus a HI/LO scoreboard.
module tb_muldiv_seq;

    localparam int LAT = 3;
    localparam logic [63:0] GARB = 64'hDEADBEEF_0BADF00D;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall_o;
    logic [31:0] mf_data;
    logic        mf_valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_signed;
    logic        div_start;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_hilo;
    logic [63:0] prod;
    logic [63:0] dexp;
    logic signed [63:0] pa;
    logic signed [63:0] pb;

    muldiv_seq #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
        .flush(flush), .stall_o(stall_o), .mf_data(mf_data), .mf_valid(mf_valid),
        .hi(hi), .lo(lo), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
        .mul_signed(mul_signed), .mul_result(mul_result), .div_opa(div_opa),
        .div_opb(div_opb), .div_signed(div_signed), .div_start(div_start),
        .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        op_valid = 1'b0;
        op       = 3'd0;
        src1     = 32'd0;
        src2     = 32'd0;
        flush    = 1'b0;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        src1     = a;
        src2     = b;
        flush    = 1'b0;
    endtask

    task automatic sb_pop(input string tag);
        logic [63:0] e;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : GARB;
        chk(tag, {hi, lo}, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        rst        = 1'b1;
        mul_result = GARB;
        div_result = GARB;
        div_ready  = 1'b0;
        exp_hilo   = 64'd0;
        nxt();
        nxt();
        rst = 1'b0;
        settle();
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_ctl", 64'({stall_o, busy, mf_valid, mul_signed, div_signed, div_start, div_annul}), 64'd0);
        chk("rst_mul", {mul_a, mul_b}, 64'd0);
        chk("rst_div", {div_opa, div_opb}, 64'd0);
        nxt();

        // MFLO straight after reset
        drive(3'd7, 32'd0, 32'd0);
        settle();
        chk("mflo_rst_data", 64'(mf_data), 64'd0);
        chk("mflo_rst_vld", 64'(mf_valid), 64'd1);
        chk("mflo_rst_stall", 64'(stall_o), 64'd0);
        nxt();

        // MULT 3 * -2
        drive(3'd0, 32'd3, 32'hFFFFFFFE);
        pa = $signed({{32{src1[31]}}, src1});
        pb = $signed({{32{src2[31]}}, src2});
        prod = 64'(pa * pb);
        exp_hilo = prod;
        sb_q.push_back(exp_hilo);
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c == LAT + 1) drive(3'd6, 32'd0, 32'd0);
            mul_result = (c == LAT) ? prod : GARB;
            settle();
            if (c <= LAT) chk($sformatf("mul_stall_c%0d", c), 64'(stall_o), 64'(c < LAT));
            if (c == 0) chk("mul_busy_c0", 64'(busy), 64'd0);
            if (c == 1) begin
                chk("mul_ops", {mul_a, mul_b}, {32'd3, 32'hFFFFFFFE});
                chk("mul_signed", 64'(mul_signed), 64'd1);
                chk("mul_busy_c1", 64'(busy), 64'd1);
            end
            if (c == LAT + 1) begin
                sb_pop("mul_hilo");
                chk("mul_hilo_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
                chk("mfhi_after_mul", 64'(mf_data), 64'hFFFFFFFF);
                chk("mul_busy_end", 64'(busy), 64'd0);
            end
            nxt();
        end
        mul_result = GARB;

        // DIVU 100 / 7, ready at c5
        drive(3'd3, 32'd100, 32'd7);
        dexp = {32'(32'd100 % 32'd7), 32'(32'd100 / 32'd7)};
        exp_hilo = dexp;
        sb_q.push_back(exp_hilo);
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) idle_in();
            div_ready  = (c == 5);
            div_result = (c == 5) ? dexp : GARB;
            settle();
            chk($sformatf("divu_start_c%0d", c), 64'(div_start), 64'(c >= 1 && c <= 5));
            if (c <= 5) chk($sformatf("divu_stall_c%0d", c), 64'(stall_o), 64'(c <= 4));
            if (c == 1) chk("divu_ops", {31'd0, div_signed, div_opa, div_opb}, {31'd0, 1'b0, 64'({32'd100, 32'd7})});
            if (c == 6) begin
                sb_pop("divu_hilo");
                chk("divu_hilo_const", {hi, lo}, {32'd2, 32'd14});
            end
            nxt();
        end
        div_ready  = 1'b0;
        div_result = GARB;

        // DIV by zero: dropped
        drive(3'd2, 32'd55, 32'd0);
        sb_q.push_back(exp_hilo);
        settle();
        chk("dz_stall", 64'(stall_o), 64'd0);
        nxt();
        idle_in();
        settle();
        chk("dz_start", 64'(div_start), 64'd0);
        chk("dz_busy", 64'(busy), 64'd0);
        sb_pop("dz_hilo");
        nxt();

        // DIV 50/3 flushed at c3 while div reports ready
        drive(3'd2, 32'd50, 32'd3);
        sb_q.push_back(exp_hilo);
        for (int c = 0; c <= 4; c++) begin
            flush      = (c == 3);
            div_ready  = (c == 3);
            div_result = GARB;
            if (c == 4) idle_in();
            settle();
            if (c == 1) chk("fl_signed", 64'(div_signed), 64'd1);
            if (c == 2) chk("fl_start_c2", 64'(div_start), 64'd1);
            if (c == 3) begin
                chk("fl_annul_c3", 64'(div_annul), 64'd1);
                chk("fl_start_c3", 64'(div_start), 64'd0);
                chk("fl_stall_c3", 64'(stall_o), 64'd0);
            end
            if (c == 4) begin
                chk("fl_busy_c4", 64'(busy), 64'd0);
                chk("fl_annul_c4", 64'(div_annul), 64'd0);
                sb_pop("fl_hilo");
            end
            nxt();
        end
        div_ready = 1'b0;

        // MTHI then MFHI; MTLO, flushed MTLO, MFLO
        drive(3'd4, 32'h12345678, 32'd0);
        settle();
        chk("mthi_stall", 64'(stall_o), 64'd0);
        chk("mthi_mf", 64'({mf_valid, mf_data}), 64'd0);
        nxt();
        drive(3'd6, 32'd0, 32'd0);
        settle();
        chk("mfhi_data", 64'(mf_data), 64'h12345678);
        chk("mfhi_vld", 64'(mf_valid), 64'd1);
        nxt();
        drive(3'd5, 32'hCAFEF00D, 32'd0);
        nxt();
        drive(3'd5, 32'h11111111, 32'd0);
        flush = 1'b1;
        settle();
        chk("fl_mt_vld", 64'(mf_valid), 64'd0);
        nxt();
        drive(3'd7, 32'd0, 32'd0);
        exp_hilo = {32'h12345678, 32'hCAFEF00D};
        sb_q.push_back(exp_hilo);
        settle();
        chk("mflo_data", 64'(mf_data), 64'hCAFEF00D);
        sb_pop("mt_hilo");
        nxt();

        // Reset in c1 of a MULTU; later product must be ignored
        drive(3'd1, 32'd5, 32'd6);
        nxt();
        settle();
        chk("rm_ops", {mul_a, mul_b}, {32'd5, 32'd6});
        chk("rm_signed", 64'(mul_signed), 64'd0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        idle_in();
        settle();
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_ctl", 64'({stall_o, mf_valid, mul_signed, div_signed, div_start, div_annul}), 64'd0);
        chk("rm_ops0", {mul_a, mul_b}, 64'd0);
        chk("rm_hilo", {hi, lo}, 64'd0);
        exp_hilo = 64'd0;
        sb_q.push_back(exp_hilo);
        nxt();
        mul_result = 64'd30;
        nxt();
        mul_result = GARB;
        nxt();
        settle();
        sb_pop("rm_late_hilo");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
